// File: rtl/idli_uart_txq_m.sv
// idli_uart_txq_m: byte-wide transmit queue between the core's 4b serial data
// path and the UART transmitter. The core pushes a byte as two nibbles (low on
// the accept cycle, high on the next). Stored bytes are replayed to the UART as
// low nibble with valid, then high nibble on the following cycle.
//
// Ports:
//   i_txq_gck      clock
//   i_txq_rst_n    asynchronous active-low reset
//   i_txq_data     nibble from core (4b)
//   i_txq_vld      core has a byte to push, sampled only with o_txq_acp
//   o_txq_acp      queue accepts a low nibble this cycle
//   o_txq_empty    no committed bytes held
//   o_txq_cnt      committed byte count, 0..DEPTH
//   o_uart_tx      nibble to UART TX (4b)
//   o_uart_tx_vld  low nibble of head byte valid
//   i_uart_tx_acp  UART accepts the low nibble; high nibble taken next cycle
module idli_uart_txq_m #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_txq_gck,
  input  logic                     i_txq_rst_n,
  input  logic [3:0]               i_txq_data,
  input  logic                     i_txq_vld,
  output logic                     o_txq_acp,
  output logic                     o_txq_empty,
  output logic [$clog2(DEPTH):0]   o_txq_cnt,
  output logic [3:0]               o_uart_tx,
  output logic                     o_uart_tx_vld,
  input  logic                     i_uart_tx_acp
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StWrLo, StWrHi} wr_state_e;
  typedef enum logic {StRdLo, StRdHi} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [7:0]      mem_q [DEPTH];
  logic [3:0]      stage_q, stage_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic lo_accept;
  logic commit;
  logic pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Write FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_txq_gck or negedge i_txq_rst_n) begin
    if (!i_txq_rst_n) begin
      wr_state_q <= StWrLo;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  // Write FSM: next state. WR_HI always returns, so only one byte is ever in
  // flight and a commit cannot overflow the count checked at low accept.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      StWrLo: if (lo_accept) wr_state_d = StWrHi;
      StWrHi: wr_state_d = StWrLo;
      default: wr_state_d = StWrLo;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    o_txq_acp = 1'b0;
    commit    = 1'b0;
    unique case (wr_state_q)
      StWrLo: o_txq_acp = !full;
      StWrHi: commit    = 1'b1;
      default: o_txq_acp = 1'b0;
    endcase
  end

  assign lo_accept = o_txq_acp & i_txq_vld;

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_txq_gck or negedge i_txq_rst_n) begin
    if (!i_txq_rst_n) begin
      rd_state_q <= StRdLo;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // Read FSM: next state
  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      StRdLo: if (o_uart_tx_vld && i_uart_tx_acp) rd_state_d = StRdHi;
      StRdHi: rd_state_d = StRdLo;
      default: rd_state_d = StRdLo;
    endcase
  end

  // Read FSM: outputs. The high nibble is driven without valid; the UART takes
  // it unconditionally the cycle after accepting the low nibble.
  always_comb begin
    o_uart_tx_vld = 1'b0;
    o_uart_tx     = 4'h0;
    pop           = 1'b0;
    unique case (rd_state_q)
      StRdLo: begin
        o_uart_tx_vld = !empty;
        if (!empty) o_uart_tx = mem_q[rd_ptr_q][3:0];
      end
      StRdHi: begin
        o_uart_tx = mem_q[rd_ptr_q][7:4];
        pop       = 1'b1;
      end
      default: o_uart_tx_vld = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_d  = stage_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (lo_accept) stage_d = i_txq_data;
    if (commit)    wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({commit, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_txq_gck or negedge i_txq_rst_n) begin
    if (!i_txq_rst_n) begin
      stage_q  <= 4'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      stage_q  <= stage_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; count gates every read of it.
  always_ff @(posedge i_txq_gck) begin
    if (commit) mem_q[wr_ptr_q] <= {i_txq_data, stage_q};
  end

  assign o_txq_empty = empty;
  assign o_txq_cnt   = count_q;

endmodule
